// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: arbitration state
// encoding and default tuning constants.
package dmem_arb_pkg;

  // Owner of the memory port in the previous cycle.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_MAX_DMA_BURST = 4;
  localparam int unsigned DEF_STARVE_LIMIT  = 8;

  // Burst/starve counters cover the 1..15 parameter range.
  localparam int unsigned ARB_CNT_W = 4;
  localparam int unsigned STATS_W   = 16;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (count -> 0)
//   inc   - increment request (ignored once count reaches LIMIT)
//   clear - synchronous clear, wins over inc
//   count - current value
module sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count < LIM)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one async-read single-port data memory between the
// CPU MEM stage and a DMA/loader requester.
// CPU wins by default; DMA is forced in after STARVE_LIMIT CPU-granted cycles
// with DMA pending, and a started DMA burst is locked for up to MAX_DMA_BURST
// cycles.
// Ports:
//   clk, reset (async active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata (combinational), cpu_stall
//   dma_req/dma_we/dma_addr/dma_wdata -> dma_gnt (combinational),
//                                        dma_rvalid/dma_rdata (registered)
//   mem_addr/mem_wdata/mem_re/mem_we  -> memory, mem_rdata <- memory
//   stall_cycles (16b, saturating) only when DMEM_ARB_STATS_EN is defined
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_DMA_BURST = DEF_MAX_DMA_BURST,
  parameter int unsigned STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] stall_cycles
`endif
);

  localparam logic [ARB_CNT_W-1:0] BURST_LIM  = ARB_CNT_W'(MAX_DMA_BURST);
  localparam logic [ARB_CNT_W-1:0] STARVE_LIM = ARB_CNT_W'(STARVE_LIMIT);

  arb_state_t state, state_nxt;
  logic grant_cpu, grant_dma;
  logic [ARB_CNT_W-1:0] burst_cnt, starve_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Grants are gated by reset so an asserted reset silences the port at once.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    state_nxt = ARB_IDLE;
    if (reset) begin
      if (state == ARB_DMA && dma_req && burst_cnt < BURST_LIM)
        grant_dma = 1'b1;
      else if (cpu_req && starve_cnt < STARVE_LIM)
        grant_cpu = 1'b1;
      else if (dma_req)
        grant_dma = 1'b1;
      else if (cpu_req)
        grant_cpu = 1'b1;
    end
    if (grant_dma)      state_nxt = ARB_DMA;
    else if (grant_cpu) state_nxt = ARB_CPU;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (grant_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
      mem_re    = ~dma_we;
    end else if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = cpu_req & ~grant_cpu;
  assign dma_gnt   = grant_dma;

  // burst_cnt saturates at the limit when DMA keeps the port uncontested,
  // so an arriving CPU request is not locked out by a fresh burst.
  sat_counter #(.WIDTH(ARB_CNT_W), .LIMIT(MAX_DMA_BURST)) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_dma),
    .clear (~grant_dma),
    .count (burst_cnt)
  );

  sat_counter #(.WIDTH(ARB_CNT_W), .LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_req & grant_cpu),
    .clear (grant_dma | ~dma_req),
    .count (starve_cnt)
  );

`ifdef DMEM_ARB_STATS_EN
  sat_counter #(.WIDTH(STATS_W), .LIMIT(32'h0000_FFFF)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_stall),
    .clear (1'b0),
    .count (stall_cycles)
  );
`endif

  // DMA read data returns one cycle after the grant; held between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= grant_dma & ~dma_we;
      if (grant_dma && !dma_we) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: constant-expectation vector table,
// directed multi-cycle sequences, and randomized traffic against a
// behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int MAXB = 4;
  localparam int STV  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_re, mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1001_0000) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  dmem_arbiter #(.MAX_DMA_BURST(MAXB), .STARVE_LIMIT(STV)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: who owned the port last cycle, length of the current DMA run,
  // CPU grants taken while DMA waited, pending read return, stall total.
  int          m_last;   // 0 none, 1 cpu, 2 dma
  int          m_run;
  int          m_wait;
  bit          m_rv;
  logic [31:0] m_rd;
  int          m_stalls;

  task automatic model_reset();
    m_last = 0; m_run = 0; m_wait = 0; m_rv = 0; m_rd = '0; m_stalls = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive after the falling edge, compare 1 time unit later,
  // then advance the model to account for the following rising edge.
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bit gd, gc;
    logic [31:0] ea, ew;
    bit ewe;
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    gd = 0; gc = 0;
    if (m_last == 2 && dr && m_run < MAXB) gd = 1;
    else if (cr && m_wait < STV)           gc = 1;
    else if (dr)                           gd = 1;
    else if (cr)                           gc = 1;
    ea  = gd ? da : ca;
    ew  = gd ? dd : cd;
    ewe = gd ? dw : cw;
    chk("dma_gnt", {31'b0, dma_gnt}, {31'b0, gd});
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cr && !gc});
    chk("mem_we", {31'b0, mem_we}, {31'b0, (gd || gc) && ewe});
    chk("mem_re", {31'b0, mem_re}, {31'b0, (gd || gc) && !ewe});
    if (gd || gc) begin
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ew);
    end
    if (gc) chk("cpu_rdata", cpu_rdata, mem_fn(ca));
    chk("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, m_rv});
    chk("dma_rdata", dma_rdata, m_rd);
`ifdef DMEM_ARB_STATS_EN
    chk("stall_cycles", {16'b0, stall_cycles}, m_stalls);
`endif
    m_last = gd ? 2 : (gc ? 1 : 0);
    m_run  = gd ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 0;
    if (gd || !dr)              m_wait = 0;
    else if (gc && m_wait < STV) m_wait++;
    m_rv = gd && !dw;
    if (m_rv) m_rd = mem_fn(da);
    if (cr && !gc && m_stalls < 65535) m_stalls++;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  typedef struct {
    bit cr;
    bit dr;
    bit exp_dgnt;
    bit exp_stall;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // Both requesters continuously active: 8 CPU cycles then 4 DMA cycles.
    for (int i = 0; i < 24; i++) begin
      tbl[i].cr        = 1'b1;
      tbl[i].dr        = 1'b1;
      tbl[i].exp_dgnt  = (i % 12) >= 8;
      tbl[i].exp_stall = (i % 12) >= 8;
    end

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dma_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("rst_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_stall_cycles", {16'b0, stall_cycles}, 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].cr, 0, 32'h1000_0000 + 32'(i * 4), '0,
           tbl[i].dr, 0, 32'h2000_0000 + 32'(i * 4), '0);
      chk("tbl_dma_gnt", {31'b0, dma_gnt}, {31'b0, tbl[i].exp_dgnt});
      chk("tbl_cpu_stall", {31'b0, cpu_stall}, {31'b0, tbl[i].exp_stall});
    end
    idle();

    // DMA-only read: same-cycle grant, data one cycle later for one cycle.
    step(0, 0, '0, '0, 1, 0, 32'h1001_0000, '0);
    chk("dma_rd_gnt", {31'b0, dma_gnt}, 32'd1);
    idle();
    chk("dma_rd_rvalid", {31'b0, dma_rvalid}, 32'd1);
    chk("dma_rd_rdata", dma_rdata, 32'hDEAD_BEEF);
    idle();
    chk("dma_rd_rvalid_drop", {31'b0, dma_rvalid}, 32'd0);

    // CPU store without DMA traffic.
    step(1, 1, 32'h1001_0004, 32'h1234_5678, 0, 0, '0, '0);
    chk("cpu_st_we", {31'b0, mem_we}, 32'd1);
    chk("cpu_st_re", {31'b0, mem_re}, 32'd0);
    chk("cpu_st_addr", mem_addr, 32'h1001_0004);
    chk("cpu_st_wdata", mem_wdata, 32'h1234_5678);
    chk("cpu_st_stall", {31'b0, cpu_stall}, 32'd0);
    idle();

    // Reset asserted in the middle of a DMA read burst.
    step(0, 0, '0, '0, 1, 0, 32'h0000_0100, '0);
    step(0, 0, '0, '0, 1, 0, 32'h0000_0104, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_dma_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("midrst_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("midrst_dma_rdata", dma_rdata, 32'd0);
    model_reset();
    @(negedge clk);
    dma_req = 0; cpu_req = 0;
    reset = 1'b1;
    step(1, 0, 32'h0000_0200, '0, 0, 0, '0, '0);
    chk("postrst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    chk("postrst_dma_gnt", {31'b0, dma_gnt}, 32'd0);

    // CPU request arrives after two cycles of a DMA burst.
    step(0, 0, '0, '0, 1, 0, 32'h0000_0300, '0);
    step(0, 0, '0, '0, 1, 0, 32'h0000_0304, '0);
    step(1, 0, 32'h0000_0400, '0, 1, 0, 32'h0000_0308, '0);
    chk("burst_hold3", {31'b0, dma_gnt}, 32'd1);
    step(1, 0, 32'h0000_0400, '0, 1, 0, 32'h0000_030C, '0);
    chk("burst_hold4", {31'b0, dma_gnt}, 32'd1);
    step(1, 0, 32'h0000_0400, '0, 1, 0, 32'h0000_0310, '0);
    chk("burst_end_dma", {31'b0, dma_gnt}, 32'd0);
    chk("burst_end_cpu", {31'b0, cpu_stall}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("burst_stall_cycles", {16'b0, stall_cycles}, 32'd2);
`endif
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom, $urandom);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DMA_BURST, default 4: max consecutive DMA-granted cycles once a DMA burst starts (range 1..15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: CPU-granted cycles with DMA pending before DMA is forced in (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req/cpu_we  input  1 each  MEM-stage access request / write enable.
REQ-006 SHALL have ports cpu_addr/cpu_wdata  input  32 each  CPU address / store data.
REQ-007 SHALL have ports cpu_rdata  output  32  (combinational mem_rdata) and cpu_stall  output  1  (cpu_req & ~CPU grant).
REQ-008 SHALL have ports dma_req/dma_we  input  1 each; dma_addr/dma_wdata  input  32 each  loader/peripheral requester.
REQ-009 SHALL have ports dma_gnt  output  1; dma_rvalid  output  1; dma_rdata  output  32 (registered).
REQ-010 SHALL have ports mem_addr/mem_wdata  output  32; mem_re/mem_we  output  1; mem_rdata  input  32 (async-read single-port memory).

Function
REQ-011 SHALL keep state ARB_IDLE/ARB_CPU/ARB_DMA = owner of previous cycle; per-cycle grant is combinational from requests and registered state.
REQ-012 SHALL grant DMA when state==ARB_DMA, dma_req=1 and burst_cnt<MAX_DMA_BURST, regardless of cpu_req (locked burst).
REQ-013 Else SHALL grant CPU when cpu_req=1 and starve_cnt<STARVE_LIMIT.
REQ-014 Else SHALL grant DMA when dma_req=1; else CPU if cpu_req=1; else none (state -> ARB_IDLE).
REQ-015 SHALL resolve simultaneous cpu_req/dma_req from ARB_IDLE or ARB_CPU to CPU unless starve_cnt==STARVE_LIMIT.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle dma_req=1 and CPU granted; clear on DMA grant or dma_req=0.
REQ-017 burst_cnt SHALL load 1 on first DMA grant after a non-DMA cycle, increment per further DMA grant, clear when DMA not granted.
REQ-018 mem_addr/mem_wdata/mem_we SHALL mux from granted requester; mem_re = grant & ~we; all mem strobes 0 with no grant.
REQ-019 dma_gnt SHALL be combinational, same cycle as the access; DMA write completes in that cycle.
REQ-020 DMA read granted in cycle t SHALL give dma_rdata=mem_rdata(t), dma_rvalid=1 in t+1 only; cpu_rdata zero-latency.
REQ-021 Requester dropping req mid-burst SHALL end the burst that cycle; no idle bubble inserted.

Reset
REQ-022 reset=0 SHALL asynchronously force state ARB_IDLE, burst_cnt=0, starve_cnt=0, dma_rvalid=0, dma_rdata=0, stats counter=0.
REQ-023 Reset mid-burst SHALL abandon the burst; first post-reset grant follows REQ-014 from ARB_IDLE.

Configuration
REQ-024 Macro DMEM_ARB_STATS_EN defined: SHALL add output stall_cycles 16 bits, counts cycles cpu_stall=1, saturates at 16'hFFFF.
REQ-025 Macro undefined: port stall_cycles and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package dmem_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_CPU, ARB_DMA) and default constants for MAX_DMA_BURST/STARVE_LIMIT.
REQ-027 Sub-module sat_counter (parameterised width/limit, inc/clear, async active-low reset) SHALL implement starve, burst and stats counters.

Verification
REQ-028 cpu_req=1 and dma_req=1 continuously from reset release -> CPU granted 8 cycles (cpu_stall=0), then DMA 4 cycles (cpu_stall=1), repeating.
REQ-029 dma_req only, read at addr 0x10010000, mem_rdata=0xDEADBEEF -> dma_gnt=1 same cycle, dma_rvalid=1 and dma_rdata=0xDEADBEEF next cycle.
REQ-030 DMA burst in cycle 2 of 4, cpu_req rises -> DMA holds 2 more cycles; CPU granted cycle 5; stall_cycles (STATS_EN) +=2.
REQ-031 reset=0 mid-burst -> dma_gnt and dma_rvalid 0 immediately; after release, cpu_req=1 alone -> CPU granted first cycle.
REQ-032 CPU store cpu_we=1 addr 0x10010004 data 0x12345678 while dma_req=0 -> mem_we=1, mem_re=0, mem_addr/mem_wdata match, cpu_stall=0.
